// File: rtl/fmcw_chirp_scheduler.sv
// FMCW chirp scheduler: frames ramp/guard cycles, tracks FFT frames still in flight,
// and stalls the next chirp while two FFT results are still owed downstream.
module fmcw_chirp_scheduler #(
  parameter int unsigned CNT_WIDTH = 16,
  parameter int unsigned CFG_WIDTH = 8
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 start,
  input  logic                 stop,
  input  logic [CNT_WIDTH-1:0] cfg_period,
  input  logic [CNT_WIDTH-1:0] cfg_ramp_len,
  input  logic [7:0]           cfg_nchirps,
  input  logic [CFG_WIDTH-1:0] cfg_window,
  input  logic                 fft_tlast,
  input  logic                 win_err,
  output logic                 ramp,
  output logic [CFG_WIDTH-1:0] win_cfg,
  output logic [7:0]           chirp_idx,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 overrun,
  output logic                 cfg_err,
  output logic                 err_latched
);

  typedef enum logic [1:0] {IDLE, RAMP, GUARD, DRAIN} state_t;

  state_t               state, state_nxt;
  logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
  logic [CNT_WIDTH-1:0] period_s, period_s_nxt;
  logic [CNT_WIDTH-1:0] ramp_len_s, ramp_len_s_nxt;
  logic [7:0]           nchirps_s, nchirps_s_nxt;
  logic [1:0]           outstanding, outstanding_nxt;
  logic                 win_err_d;
  logic                 ramp_nxt, busy_nxt, frame_done_nxt;
  logic                 overrun_nxt, cfg_err_nxt, err_latched_nxt;
  logic [CFG_WIDTH-1:0] win_cfg_nxt;
  logic [7:0]           chirp_idx_nxt;

  logic       cfg_ok, tlast_eff, ramp_end, guard_end, last_chirp, ramp_entry;
  logic [1:0] out_dec;

  assign cfg_ok     = (cfg_ramp_len != '0) && (cfg_ramp_len < cfg_period);
  assign tlast_eff  = fft_tlast && (outstanding != 2'd0);
  assign out_dec    = outstanding - 2'(tlast_eff);
  assign ramp_end   = (cnt == ramp_len_s - CNT_WIDTH'(1));
  assign guard_end  = (cnt == period_s - ramp_len_s - CNT_WIDTH'(1));
  assign last_chirp = (nchirps_s != 8'd0) && (8'(chirp_idx + 8'd1) == nchirps_s);
  assign ramp_entry = (state_nxt == RAMP) && (state != RAMP);

  // State and datapath registers
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state       <= IDLE;
      cnt         <= '0;
      period_s    <= '0;
      ramp_len_s  <= '0;
      nchirps_s   <= '0;
      outstanding <= '0;
      win_err_d   <= 1'b0;
      ramp        <= 1'b0;
      win_cfg     <= '0;
      chirp_idx   <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      overrun     <= 1'b0;
      cfg_err     <= 1'b0;
      err_latched <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      period_s    <= period_s_nxt;
      ramp_len_s  <= ramp_len_s_nxt;
      nchirps_s   <= nchirps_s_nxt;
      outstanding <= outstanding_nxt;
      win_err_d   <= win_err;
      ramp        <= ramp_nxt;
      win_cfg     <= win_cfg_nxt;
      chirp_idx   <= chirp_idx_nxt;
      busy        <= busy_nxt;
      frame_done  <= frame_done_nxt;
      overrun     <= overrun_nxt;
      cfg_err     <= cfg_err_nxt;
      err_latched <= err_latched_nxt;
    end
  end

  // Next-state logic; the stall decision uses the count after this cycle's tlast
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start && cfg_ok) state_nxt = RAMP;
      RAMP: begin
        if (stop)          state_nxt = DRAIN;
        else if (ramp_end) state_nxt = GUARD;
      end
      GUARD: begin
        if (stop)                              state_nxt = DRAIN;
        else if (guard_end && out_dec != 2'd2) state_nxt = last_chirp ? DRAIN : RAMP;
      end
      DRAIN: if (out_dec == 2'd0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered-output and datapath next values
  always_comb begin
    cnt_nxt         = cnt;
    period_s_nxt    = period_s;
    ramp_len_s_nxt  = ramp_len_s;
    nchirps_s_nxt   = nchirps_s;
    outstanding_nxt = out_dec + 2'(ramp_entry);
    ramp_nxt        = (state_nxt == RAMP);
    busy_nxt        = (state_nxt != IDLE);
    frame_done_nxt  = (state == DRAIN) && (state_nxt == IDLE);
    win_cfg_nxt     = win_cfg;
    chirp_idx_nxt   = chirp_idx;
    overrun_nxt     = overrun;
    cfg_err_nxt     = cfg_err;
    err_latched_nxt = err_latched;

    if (state_nxt != state)
      cnt_nxt = '0;
    else if ((state == RAMP) || ((state == GUARD) && !guard_end))
      cnt_nxt = cnt + CNT_WIDTH'(1);

    if (ramp_entry) begin
      win_cfg_nxt   = cfg_window;
      chirp_idx_nxt = (state == IDLE) ? 8'd0 : 8'(chirp_idx + 8'd1);
    end

    if ((state == IDLE) && start) begin
      if (cfg_ok) begin
        period_s_nxt    = cfg_period;
        ramp_len_s_nxt  = cfg_ramp_len;
        nchirps_s_nxt   = cfg_nchirps;
        overrun_nxt     = 1'b0;
        cfg_err_nxt     = 1'b0;
        err_latched_nxt = 1'b0;
      end else begin
        cfg_err_nxt = 1'b1;
      end
    end

    if ((state == GUARD) && !stop && guard_end && (outstanding == 2'd2))
      overrun_nxt = 1'b1;

    if ((state != IDLE) && win_err && !win_err_d)
      err_latched_nxt = 1'b1;
  end

endmodule

// File: tb/tb_fmcw_chirp_scheduler.sv
// Scoreboard bench for fmcw_chirp_scheduler: stimulus queues expected ramp rises and
// frame_done pulses, a negedge monitor pops and compares them as the DUT produces them.
module tb_fmcw_chirp_scheduler;

  logic        aclk = 1'b0;
  logic        aresetn, start, stop, fft_tlast, win_err;
  logic [15:0] cfg_period, cfg_ramp_len;
  logic [7:0]  cfg_nchirps, cfg_window;
  logic        ramp, busy, frame_done, overrun, cfg_err, err_latched;
  logic [7:0]  win_cfg, chirp_idx;

  typedef struct {
    bit         fd;
    int         cyc;
    logic [7:0] idx;
    logic [7:0] win;
  } ev_t;

  ev_t  exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   base;
  logic ramp_q = 1'b0;

  fmcw_chirp_scheduler #(.CNT_WIDTH(16), .CFG_WIDTH(8)) dut (
    .aclk(aclk), .aresetn(aresetn), .start(start), .stop(stop),
    .cfg_period(cfg_period), .cfg_ramp_len(cfg_ramp_len), .cfg_nchirps(cfg_nchirps),
    .cfg_window(cfg_window), .fft_tlast(fft_tlast), .win_err(win_err),
    .ramp(ramp), .win_cfg(win_cfg), .chirp_idx(chirp_idx), .busy(busy),
    .frame_done(frame_done), .overrun(overrun), .cfg_err(cfg_err), .err_latched(err_latched)
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endfunction

  task automatic push_rise(int c, logic [7:0] idx, logic [7:0] win);
    ev_t e;
    e.fd = 1'b0; e.cyc = c; e.idx = idx; e.win = win;
    exp_q.push_back(e);
  endtask

  task automatic push_fd(int c);
    ev_t e;
    e.fd = 1'b1; e.cyc = c; e.idx = 8'd0; e.win = 8'd0;
    exp_q.push_back(e);
  endtask

  task automatic take(bit fd, logic [7:0] idx, logic [7:0] win);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_event kind=%0d at cycle %0d, none expected", fd, cyc);
    end else begin
      e = exp_q.pop_front();
      check("ev_kind", 32'(fd), 32'(e.fd));
      check("ev_cycle", 32'(cyc), 32'(e.cyc));
      if (!fd) check("ev_idx_win", {16'd0, idx, win}, {16'd0, e.idx, e.win});
    end
  endtask

  // Monitor: ramp rising edges and frame_done pulses against the expected queue
  always @(negedge aclk) begin
    if (ramp && !ramp_q) take(1'b0, chirp_idx, win_cfg);
    if (frame_done) take(1'b1, 8'd0, 8'd0);
    ramp_q = ramp;
  end

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic set_cfg(int p, int r, int n, logic [7:0] w);
    cfg_period   = 16'(p);
    cfg_ramp_len = 16'(r);
    cfg_nchirps  = 8'(n);
    cfg_window   = w;
  endtask

  task automatic idle_inputs();
    start = 1'b0; stop = 1'b0; fft_tlast = 1'b0; win_err = 1'b0;
  endtask

  initial begin
    aresetn = 1'b0;
    idle_inputs();
    set_cfg(0, 0, 0, 8'h00);
    fft_tlast = 1'b1;
    win_err   = 1'b1;
    repeat (3) step();
    check("reset_outputs",
          {14'd0, ramp, busy, frame_done, overrun, cfg_err, err_latched, chirp_idx, win_cfg}, 32'd0);
    aresetn = 1'b1;
    idle_inputs();
    step();

    // tlast with nothing outstanding must not underflow
    fft_tlast = 1'b1; step(); step();
    fft_tlast = 1'b0; step();

    // Three-chirp frame, tlast arrives 4 cycles after each ramp fall
    set_cfg(10, 6, 3, 8'h11);
    base = cyc;
    push_rise(base + 1, 8'd0, 8'h11);
    push_rise(base + 11, 8'd1, 8'h11);
    push_rise(base + 21, 8'd2, 8'h11);
    push_fd(base + 32);
    for (int t = 0; t < 36; t++) begin
      if (t == 5)  check("s1_busy_mid", 32'(busy), 32'd1);
      if (t == 8)  check("s1_ramp_guard", 32'(ramp), 32'd0);
      if (t == 32) check("s1_busy_end", 32'(busy), 32'd0);
      start     = (t == 0);
      fft_tlast = (t == 11 || t == 21 || t == 31);
      step();
    end
    idle_inputs();

    // ramp_len equal to period is rejected
    set_cfg(10, 10, 1, 8'h22);
    for (int t = 0; t < 5; t++) begin
      if (t == 2) check("s2_cfg_err", {29'd0, cfg_err, busy, ramp}, 32'b100);
      start = (t == 0);
      step();
    end
    // Valid start with simultaneous stop; start wins and clears cfg_err
    set_cfg(8, 3, 1, 8'h33);
    base = cyc;
    push_rise(base + 1, 8'd0, 8'h33);
    push_fd(base + 10);
    for (int t = 0; t < 13; t++) begin
      if (t == 1) check("s2_cfg_err_clr", 32'(cfg_err), 32'd0);
      start     = (t == 0);
      stop      = (t == 0);
      fft_tlast = (t == 9);
      step();
    end
    idle_inputs();

    // Continuous mode without tlast stalls on the third chirp and flags overrun
    set_cfg(6, 2, 0, 8'h5A);
    base = cyc;
    push_rise(base + 1, 8'd0, 8'h5A);
    push_rise(base + 7, 8'd1, 8'h5A);
    push_rise(base + 16, 8'd2, 8'h5A);
    push_fd(base + 20);
    for (int t = 0; t < 23; t++) begin
      if (t == 12) check("s3_overrun_pre", 32'(overrun), 32'd0);
      if (t == 13) check("s3_overrun", {30'd0, overrun, busy}, 32'b11);
      if (t == 22) check("s3_idle", {30'd0, busy, overrun}, 32'b01);
      start     = (t == 0);
      fft_tlast = (t == 15 || t == 18 || t == 19);
      stop      = (t == 17);
      step();
    end
    idle_inputs();

    // win_err in IDLE is ignored
    win_err = 1'b1; step();
    win_err = 1'b0; step();
    check("idle_win_err", 32'(err_latched), 32'd0);

    // Window staging, win_err latch and stop in the third RAMP cycle
    set_cfg(10, 6, 0, 8'h25);
    base = cyc;
    push_rise(base + 1, 8'd0, 8'h25);
    push_rise(base + 11, 8'd1, 8'h43);
    push_fd(base + 16);
    for (int t = 0; t < 19; t++) begin
      if (t == 1)  check("s4_overrun_clr", 32'(overrun), 32'd0);
      if (t == 5)  check("s4_win_hold", 32'(win_cfg), 32'h25);
      if (t == 6)  check("s4_err_latched", 32'(err_latched), 32'd1);
      if (t == 10) check("s4_win_hold2", 32'(win_cfg), 32'h25);
      if (t == 14) check("s4_stop_drain", {30'd0, ramp, busy}, 32'b01);
      if (t == 17) check("s4_idle", 32'(busy), 32'd0);
      start      = (t == 0);
      cfg_window = (t >= 2) ? 8'h43 : 8'h25;
      win_err    = (t == 4);
      fft_tlast  = (t == 8 || t == 15);
      stop       = (t == 13);
      step();
    end
    idle_inputs();

    // Reset pulse during GUARD, then a fresh frame
    set_cfg(8, 3, 0, 8'h77);
    base = cyc;
    push_rise(base + 1, 8'd0, 8'h77);
    push_rise(base + 8, 8'd0, 8'h77);
    push_fd(base + 12);
    for (int t = 0; t < 15; t++) begin
      if (t == 6)
        check("s5_reset_outputs",
              {14'd0, ramp, busy, frame_done, overrun, cfg_err, err_latched, chirp_idx, win_cfg}, 32'd0);
      aresetn   = (t != 5);
      start     = (t == 0 || t == 7);
      stop      = (t == 9);
      fft_tlast = (t == 11);
      step();
    end
    idle_inputs();
    repeat (3) step();

    check("events_pending", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fmcw_chirp_scheduler.md
FMCW_CHIRP_SCHEDULER -- requirements
Module: fmcw_chirp_scheduler

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 16, width of the period and ramp-length counters.
REQ-002 SHALL have parameter CFG_WIDTH, default 8, width of the window configuration word.
REQ-003 SHALL have port aclk  input  1  clock; all logic is on the rising edge.
REQ-004 SHALL have port aresetn  input  1  synchronous, active-low reset.
REQ-005 SHALL have port start  input  1  level; sampled in IDLE only.
REQ-006 SHALL have port stop  input  1  level; aborts the frame.
REQ-007 SHALL have port cfg_period  input  CNT_WIDTH  ramp-to-ramp period in clocks.
REQ-008 SHALL have port cfg_ramp_len  input  CNT_WIDTH  ramp-high duration in clocks.
REQ-009 SHALL have port cfg_nchirps  input  8  chirps per frame; 0 means continuous.
REQ-010 SHALL have port cfg_window  input  CFG_WIDTH  staged window configuration.
REQ-011 SHALL have port fft_tlast  input  1  one pulse per completed FFT frame.
REQ-012 SHALL have port win_err  input  1  window-too-small flag from the window stage.
REQ-013 SHALL have port ramp  output  1  chirp trigger to the window stage and DAC.
REQ-014 SHALL have port win_cfg  output  CFG_WIDTH  configuration driven to the window stage.
REQ-015 SHALL have port chirp_idx  output  8  0-based index of the current chirp.
REQ-016 SHALL have ports busy, frame_done, overrun, cfg_err and err_latched  output  1 each  status signals.

Function
REQ-017 SHALL implement states IDLE, RAMP, GUARD and DRAIN.
REQ-018 In IDLE with start=1, SHALL capture cfg_period, cfg_ramp_len and cfg_nchirps into shadow registers; these shadows are used for the whole frame.
REQ-019 SHALL treat the configuration as invalid when cfg_ramp_len=0 or cfg_ramp_len>=cfg_period.
REQ-020 When the configuration is invalid, SHALL set cfg_err (sticky), stay in IDLE and not assert ramp.
REQ-021 With a valid configuration, SHALL enter RAMP on the next edge; ramp=1 starts the cycle after start is sampled.
REQ-022 SHALL register ramp, so that ramp=1 exactly when state=RAMP.
REQ-023 RAMP SHALL last shadow ramp_len cycles, then go to GUARD.
REQ-024 GUARD SHALL last (period - ramp_len) cycles, so that ramp rises repeat with exactly the shadow period.
REQ-025 On every RAMP entry, SHALL load win_cfg from cfg_window on the same edge that ramp rises; win_cfg is otherwise held.
REQ-026 On every RAMP entry, SHALL increment the 2-bit outstanding counter and set chirp_idx; chirp_idx is 0 for the first chirp and increments by 1 per chirp, wrapping 255->0.
REQ-027 Each fft_tlast SHALL decrement the outstanding counter; a simultaneous chirp start and fft_tlast SHALL leave it unchanged.
REQ-028 fft_tlast when outstanding=0 SHALL be ignored, with no underflow.
REQ-029 At the end of GUARD, if outstanding=2, SHALL set overrun (sticky) and stay in GUARD until outstanding<2, then enter RAMP on the next edge.
REQ-030 At the end of GUARD with nchirps non-zero and chirp_idx+1=nchirps, SHALL go to DRAIN instead of RAMP.
REQ-031 With nchirps=0, SHALL run until stop.
REQ-032 DRAIN SHALL wait for outstanding=0, then pulse frame_done high for 1 cycle and return to IDLE.
REQ-033 stop=1 in RAMP or GUARD SHALL force DRAIN on the next edge, so ramp falls 1 cycle after stop.
REQ-034 stop=1 in IDLE or DRAIN SHALL have no effect.
REQ-035 start while not in IDLE SHALL be ignored.
REQ-036 start and stop asserted together in IDLE: start SHALL take precedence.
REQ-037 A rising edge of win_err in any state except IDLE SHALL set err_latched (sticky); the sequence continues.
REQ-038 SHALL clear cfg_err, overrun and err_latched only on a valid start accepted in IDLE, or on reset.
REQ-039 busy SHALL be 1 in every state except IDLE.

Reset
REQ-040 With aresetn=0 at a clock edge, SHALL set state=IDLE and outputs ramp=0, win_cfg=0, chirp_idx=0, busy=0, frame_done=0, overrun=0, cfg_err=0, err_latched=0; all counters SHALL reset to 0.
REQ-041 Reset asserted mid-frame SHALL drop ramp on the next edge and lose all outstanding counts.
REQ-042 SHALL ignore fft_tlast and win_err while aresetn=0.

Verification
REQ-043 period=10, ramp_len=6, nchirps=3, start at cycle 0, fft_tlast 4 cycles after each ramp fall -> ramp high on cycles 1-6, 11-16 and 21-26; chirp_idx 0,1,2; frame_done one cycle after the third fft_tlast; busy then 0.
REQ-044 ramp_len=10, period=10 -> cfg_err=1, ramp stays 0, busy=0; a following valid start clears cfg_err.
REQ-045 nchirps=0 with fft_tlast never asserted -> chirps 0 and 1 issued, overrun=1 at the end of the second GUARD, ramp held low; one fft_tlast -> next ramp rises 1 cycle later.
REQ-046 stop during the third cycle of RAMP, outstanding=1 -> ramp=0 next cycle, state DRAIN; fft_tlast -> frame_done pulse, IDLE.
REQ-047 cfg_window changed from 0x25 to 0x43 mid-chirp -> win_cfg stays 0x25 until the next ramp rise, then 0x43 on the same edge.
REQ-048 aresetn low for 1 cycle during GUARD -> all outputs 0 the next cycle; start after release -> normal frame with chirp_idx=0.
